// File: rtl/dice_pkg.sv
// dice_pkg: shared widths, die range, FSM encoding and roll classification for the dice game
package dice_pkg;
  localparam int DIE_W = 3;
  localparam int SUM_W = 4;
  localparam logic [DIE_W-1:0] DIE_MIN = 3'd1;
  localparam logic [DIE_W-1:0] DIE_MAX = 3'd6;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SAMPLE = 2'd1;
  localparam logic [1:0] EVAL   = 2'd2;
  localparam logic [1:0] REPORT = 2'd3;
  function automatic logic is_craps(input logic [SUM_W-1:0] s);
    return s == 4'd2 || s == 4'd3 || s == 4'd12;
  endfunction
  function automatic logic is_natural(input logic [SUM_W-1:0] s);
    return s == 4'd7 || s == 4'd11;
  endfunction
endpackage

// File: rtl/dice_pair_counter.sv
// dice_pair_counter: free-running chained 1..6 die counters with a 36-cycle joint period
module dice_pair_counter
  import dice_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  output logic [DIE_W-1:0] die_a_raw,
  output logic [DIE_W-1:0] die_b_raw
);
  // die_a steps every cycle; die_b steps when die_a wraps
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      die_a_raw <= DIE_MIN;
      die_b_raw <= DIE_MIN;
    end else begin
      die_a_raw <= die_a_raw == DIE_MAX ? DIE_MIN : die_a_raw + 1'b1;
      if (die_a_raw == DIE_MAX) die_b_raw <= die_b_raw == DIE_MAX ? DIE_MIN : die_b_raw + 1'b1;
    end
endmodule

// File: rtl/dice_turn_arbiter.sv
// dice_turn_arbiter: two-player turn sequencer sharing one dice datapath with craps-style scoring
module dice_turn_arbiter
  import dice_pkg::*;
#(
  parameter int MAX_CHANCES = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req,
  input  logic [1:0]       new_game,
  output logic [1:0]       grant,
  output logic [DIE_W-1:0] die_a,
  output logic [DIE_W-1:0] die_b,
  output logic [SUM_W-1:0] sum,
  output logic             done,
  output logic             win,
  output logic             decided,
  output logic [1:0]       over,
  output logic [1:0]       chances0,
  output logic [1:0]       chances1
);
  localparam logic [1:0] MAXC = 2'(MAX_CHANCES);
  logic [1:0]       state, nxt, elig, pick, busy, pend;
  logic             last;
  logic [DIE_W-1:0] die_a_raw, die_b_raw, cap_a, cap_b;
  logic [SUM_W-1:0] eval_sum;
  logic [1:0]       ch [2];
  logic [1:0]       ch_dec;
  logic             eval_fixed, eval_dec;
  dice_pair_counter u_cnt (
    .clk       (clk),
    .reset_n   (reset_n),
    .die_a_raw (die_a_raw),
    .die_b_raw (die_b_raw)
  );
  assign chances0 = ch[0];
  assign chances1 = ch[1];
  // eligibility, round-robin pick, next state and roll outcome of the captured dice
  always_comb begin
    elig       = req & ~over;
    pick       = elig == 2'b11 ? (last ? 2'b01 : 2'b10) : elig;
    nxt        = state == IDLE ? (|elig ? SAMPLE : IDLE) : state == REPORT ? IDLE : state + 2'd1;
    busy       = state != IDLE ? grant : 2'b00;
    eval_sum   = SUM_W'(cap_a) + SUM_W'(cap_b);
    ch_dec     = (grant[1] ? ch[1] : ch[0]) - 2'd1;
    eval_fixed = is_craps(eval_sum) || is_natural(eval_sum);
    eval_dec   = eval_fixed || ch_dec == 2'd0;
  end
  // turn sequencing: grant in IDLE, capture in SAMPLE, publish results at the EVAL->REPORT edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state   <= IDLE;
      grant   <= 2'b00;
      last    <= 1'b1;
      cap_a   <= '0;
      cap_b   <= '0;
      die_a   <= '0;
      die_b   <= '0;
      sum     <= '0;
      done    <= 1'b0;
      win     <= 1'b0;
      decided <= 1'b0;
    end else begin
      state <= nxt;
      done  <= state == EVAL;
      if (state == IDLE) grant <= pick;
      if (state == REPORT) grant <= 2'b00;
      if (state == IDLE && |elig) last <= pick[1];
      if (state == SAMPLE) begin
        cap_a <= die_a_raw;
        cap_b <= die_b_raw;
      end
      if (state == EVAL) begin
        die_a   <= cap_a;
        die_b   <= cap_b;
        sum     <= eval_sum;
        win     <= is_natural(eval_sum);
        decided <= eval_dec;
      end
    end
  // per-player chances/over; a new_game for the served player waits and overrides the roll on exit
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ch   <= '{MAXC, MAXC};
      over <= 2'b00;
      pend <= 2'b00;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (busy[p] ? (state == REPORT && (pend[p] || new_game[p])) : new_game[p]) begin
          ch[p]   <= MAXC;
          over[p] <= 1'b0;
        end else if (busy[p] && state == EVAL) begin
          if (!eval_fixed) ch[p] <= ch_dec;
          if (eval_dec) over[p] <= 1'b1;
        end
        pend[p] <= busy[p] && state != REPORT && (pend[p] || new_game[p]);
      end
    end
endmodule

// File: tb/tb_dice_turn_arbiter.sv
// tb_dice_turn_arbiter: directed turns with a scoreboard checked on every done pulse
module tb_dice_turn_arbiter;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] new_game = 2'b00;
  logic [1:0] grant, over, chances0, chances1;
  logic [2:0] die_a, die_b;
  logic [3:0] sum;
  logic       done, win, decided;
  int         cyc, checks, errors;
  typedef struct {
    logic [1:0] g;
    logic [2:0] a, b;
    logic [3:0] s;
    logic       w, d;
    logic [1:0] ov, c0, c1;
  } exp_t;
  exp_t q[$];
  exp_t e;
  dice_turn_arbiter #(.MAX_CHANCES(3)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .new_game (new_game),
    .grant    (grant),
    .die_a    (die_a),
    .die_b    (die_b),
    .sum      (sum),
    .done     (done),
    .win      (win),
    .decided  (decided),
    .over     (over),
    .chances0 (chances0),
    .chances1 (chances1)
  );
  always #5 clk = ~clk;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else cyc <= cyc + 1;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", n, act, exp);
    end
  endtask
  function automatic exp_t mk(input logic [1:0] g, input int a, input int b, input int s,
                              input logic w, input logic d, input logic [1:0] ov, input int c0, input int c1);
    mk = '{g, 3'(a), 3'(b), 4'(s), w, d, ov, 2'(c0), 2'(c1)};
  endfunction
  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic turn(input int p, input int k, input exp_t x);
    at(k);
    req[p] = 1'b1;
    q.push_back(x);
    at(k + 1);
    req[p] = 1'b0;
  endtask
  always @(negedge clk)
    if (reset_n && done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("done_grant", grant, e.g);
        chk("done_die_a", die_a, e.a);
        chk("done_die_b", die_b, e.b);
        chk("done_sum", sum, e.s);
        chk("done_win", win, e.w);
        chk("done_decided", decided, e.d);
        chk("done_over", over, e.ov);
        chk("done_chances0", chances0, e.c0);
        chk("done_chances1", chances1, e.c1);
      end
    end
  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_die_a", die_a, 0);
    chk("rst_die_b", die_b, 0);
    chk("rst_sum", sum, 0);
    chk("rst_done", done, 0);
    chk("rst_win", win, 0);
    chk("rst_decided", decided, 0);
    chk("rst_over", over, 0);
    chk("rst_chances0", chances0, 3);
    chk("rst_chances1", chances1, 3);
    reset_n = 1'b1;
    chk("cnt0_a", dut.u_cnt.die_a_raw, 1);
    chk("cnt0_b", dut.u_cnt.die_b_raw, 1);
    at(1);
    chk("cnt1_a", dut.u_cnt.die_a_raw, 2);
    chk("cnt1_b", dut.u_cnt.die_b_raw, 1);
    turn(0, 4, mk(2'b01, 6, 1, 7, 1, 1, 2'b01, 3, 3));
    at(8);
    req = 2'b01;
    at(9);  chk("over_p0_grant9", grant, 0);
    at(10); chk("over_p0_grant10", grant, 0);
    at(11); chk("over_p0_grant11", grant, 0);
    at(12);
    req = 2'b00;
    new_game = 2'b01;
    at(13);
    new_game = 2'b00;
    chk("ng_idle_over", over, 0);
    chk("ng_idle_chances0", chances0, 3);
    turn(1, 35, mk(2'b10, 1, 1, 2, 0, 1, 2'b10, 3, 3));
    at(39);
    req = 2'b10;
    at(40); chk("over_p1_grant40", grant, 0);
    at(41); chk("over_p1_grant41", grant, 0);
    req = 2'b00;
    turn(0, 42, mk(2'b01, 2, 2, 4, 0, 0, 2'b10, 2, 3));
    turn(0, 48, mk(2'b01, 2, 3, 5, 0, 0, 2'b10, 1, 3));
    turn(0, 54, mk(2'b01, 2, 4, 6, 0, 1, 2'b11, 0, 3));
    at(60);
    new_game = 2'b11;
    at(61);
    new_game = 2'b00;
    at(62);
    req = 2'b11;
    q.push_back(mk(2'b10, 4, 5, 9, 0, 0, 2'b00, 3, 2));
    q.push_back(mk(2'b01, 2, 6, 8, 0, 0, 2'b00, 2, 2));
    q.push_back(mk(2'b10, 6, 6, 12, 0, 1, 2'b10, 2, 2));
    q.push_back(mk(2'b01, 4, 1, 5, 0, 0, 2'b10, 1, 2));
    q.push_back(mk(2'b01, 2, 2, 4, 0, 1, 2'b11, 0, 2));
    at(83); chk("both_over_grant83", grant, 0);
    at(84); chk("both_over_grant84", grant, 0);
    req = 2'b00;
    at(85);
    new_game = 2'b11;
    at(86);
    new_game = 2'b00;
    turn(0, 86, mk(2'b01, 4, 3, 7, 1, 1, 2'b01, 3, 3));
    new_game = 2'b01;
    at(88);
    new_game = 2'b00;
    at(90);
    chk("ng_turn_over", over, 0);
    chk("ng_turn_chances0", chances0, 3);
    at(92);
    req = 2'b01;
    at(93);
    req = 2'b00;
    at(94);
    chk("mid_grant_before", grant, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_grant", grant, 0);
    chk("mid_done", done, 0);
    chk("mid_over", over, 0);
    chk("mid_chances0", chances0, 3);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
